temp_pulse_uart_sequencer: RTL

- Measurement/transmit sequencer for the UART temperature-sensor design.
- Measures the width, in clk cycles, of each low pulse on the sensor pulse input (sensor drives high when idle and pulses low for a temperature-dependent time).
- Latches the measured value, then sequences a 3-byte frame into the UART transmitter over a valid/ready handshake.
- Sits between the pad input (ui_in[0]) and the UART TX core.

---
 rtl/temp_pulse_uart_sequencer.sv | 106 ++++++++++
 1 files changed

// File: rtl/temp_pulse_uart_sequencer.sv
// temp_pulse_uart_sequencer: measures low-pulse width on a sensor input and sends it as a 3-byte UART frame
//   clk          system clock
//   rst          synchronous active-high reset
//   enable_i     measurement enable; low aborts ARM/COUNT, lets a frame finish then idles
//   sens_in_i    asynchronous sensor pulse, idle high, active low
//   tx_ready_i   UART TX accepts the offered byte this cycle
//   tx_valid_o   byte on tx_data_o is offered
//   tx_data_o    frame byte: header, {overflow, value[CNT_W-1:8]}, value[7:0]
//   meas_value_o last measured low-pulse width in cycles
//   meas_valid_o one-cycle strobe when meas_value_o updates
//   overflow_o   last measurement saturated
//   busy_o       any state other than IDLE
module temp_pulse_uart_sequencer #(
    parameter int unsigned CNT_W    = 11,
    parameter logic [7:0]  HDR_BYTE = 8'hA5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_i,
    input  logic             sens_in_i,
    input  logic             tx_ready_i,
    output logic             tx_valid_o,
    output logic [7:0]       tx_data_o,
    output logic [CNT_W-1:0] meas_value_o,
    output logic             meas_valid_o,
    output logic             overflow_o,
    output logic             busy_o
);
    typedef enum logic [2:0] {IDLE, ARM, COUNT, SEND_HDR, SEND_HI, SEND_LO} state_e;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    state_e           state_q;
    logic             s_meta_q, s_sync_q, s_prev_q, sat_q;
    logic [CNT_W-1:0] cnt_q;
    logic             fall;
    // only a genuine high-to-low transition starts a measurement
    assign fall = s_prev_q & ~s_sync_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            s_meta_q     <= 1'b1;
            s_sync_q     <= 1'b1;
            s_prev_q     <= 1'b1;
            sat_q        <= 1'b0;
            cnt_q        <= '0;
            tx_valid_o   <= 1'b0;
            tx_data_o    <= 8'h00;
            meas_value_o <= '0;
            meas_valid_o <= 1'b0;
            overflow_o   <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            s_meta_q     <= sens_in_i;
            s_sync_q     <= s_meta_q;
            s_prev_q     <= s_sync_q;
            meas_valid_o <= 1'b0;
            case (state_q)
                IDLE: if (enable_i) begin
                    state_q <= ARM;
                    busy_o  <= 1'b1;
                end
                ARM: if (!enable_i) begin
                    state_q <= IDLE;
                    busy_o  <= 1'b0;
                end else if (fall) begin
                    cnt_q   <= CNT_W'(1);
                    sat_q   <= 1'b0;
                    state_q <= COUNT;
                end
                COUNT: if (!enable_i) begin
                    state_q <= IDLE;
                    busy_o  <= 1'b0;
                end else if (s_sync_q) begin
                    meas_value_o <= cnt_q;
                    overflow_o   <= sat_q;
                    meas_valid_o <= 1'b1;
                    tx_valid_o   <= 1'b1;
                    tx_data_o    <= HDR_BYTE;
                    state_q      <= SEND_HDR;
                end else if (cnt_q == CNT_MAX) begin
                    sat_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                // measurement registers are already updated when the header is on the bus
                SEND_HDR: if (tx_ready_i) begin
                    tx_data_o <= {overflow_o, 7'(meas_value_o >> 8)};
                    state_q   <= SEND_HI;
                end
                SEND_HI: if (tx_ready_i) begin
                    tx_data_o <= meas_value_o[7:0];
                    state_q   <= SEND_LO;
                end
                SEND_LO: if (tx_ready_i) begin
                    tx_valid_o <= 1'b0;
                    tx_data_o  <= 8'h00;
                    state_q    <= enable_i ? ARM : IDLE;
                    busy_o     <= enable_i;
                end
                default: begin
                    state_q <= IDLE;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end
endmodule
